traffic_phase_scheduler: RTL

// - Decides which phase the traffic light controller serves next: M1 through, M2 through, MT turn, or S side road.
// - Latches vehicle-sensor requests and grants phases round-robin, with an aging override so no request starves.
// - Supports emergency preemption and enforces an all-red clearance interval between phases.
// - Sits between the sensor/emergency inputs and the traffic_light_controller. The controller runs the G->Y sequence for the granted phase.

---
 rtl/traffic_pkg.sv | 25 ++
 rtl/rr_arbiter4.sv | 34 +++
 rtl/traffic_phase_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light scheduler and controller.
//   phase_t : the four served phases (M1, M2 through, MT turn, S side road)
//   state_t : scheduler FSM states
//   LIGHT_* : {R,Y,G} lamp encoding used by traffic_light_controller
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_M1 = 2'd0,
        PH_M2 = 2'd1,
        PH_MT = 2'd2,
        PH_S  = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACTIVE,
        CLEAR
    } state_t;

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick.
//   req : request vector, bit n = phase n
//   ptr : index that has highest priority this pick
//   gnt : one-hot of the chosen request (0 when req is empty)
//   idx : index of the chosen request
//   hit : at least one request is present
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] idx,
    output logic       hit
);

    logic [1:0] k;

    // Walk from the farthest offset down to ptr so the nearest request wins last.
    always_comb begin
        gnt = 4'b0000;
        idx = 2'd0;
        k   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            k = ptr + 2'(i);
            if (req[k]) begin
                gnt    = 4'b0000;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

    assign hit = |req;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Picks the next phase for the traffic light controller.
// Sensor requests are latched into a pending vector, granted round-robin with a
// starvation override, emergency requests preempt, and every phase is followed
// by an all-red clearance interval.
//   clk, rst        : clock, asynchronous active-low reset
//   req_i           : sensor requests per phase (level or pulse)
//   emerg_req       : emergency preemption request (level)
//   grant_ready     : controller accepts the offered grant
//   phase_done      : controller finished the granted phase's yellow
//   grant_valid     : grant offer valid
//   grant_phase     : offered phase
//   grant_cycles    : green duration of the offered phase
//   abort           : one-cycle pulse forcing the running phase to end
//   all_red         : clearance interval active
//   emerg_active    : offered/running phase is an emergency phase
//   pending_o       : latched pending-request vector
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_M      = 40,
    parameter int GREEN_T      = 15,
    parameter int GREEN_S      = 25,
    parameter int CLEAR_CYCLES = 4,
    parameter int STARVE_LIMIT = 200,
    parameter int EMERG_PHASE  = 0,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_i,
    input  logic             emerg_req,
    input  logic             grant_ready,
    input  logic             phase_done,
    output logic             grant_valid,
    output logic [1:0]       grant_phase,
    output logic [CNT_W-1:0] grant_cycles,
    output logic             abort,
    output logic             all_red,
    output logic             emerg_active,
    output logic [3:0]       pending_o
);

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_CYCLES);
    localparam logic [1:0]       EPH      = 2'(EMERG_PHASE);

    state_t           state;
    logic [3:0]       pending, starved, grant_oh, clr_mask;
    logic [CNT_W-1:0] wait_cnt [4];
    logic [CNT_W-1:0] clr_cnt;
    logic [1:0]       rr_ptr;
    logic [3:0]       st_gnt, rr_gnt;
    logic [1:0]       st_idx, rr_idx;
    logic             st_hit, rr_hit;
    logic             withdraw, handshake;

    function automatic logic [CNT_W-1:0] green_of(input logic [1:0] ph);
        case (phase_t'(ph))
            PH_MT:   green_of = CNT_W'(GREEN_T);
            PH_S:    green_of = CNT_W'(GREEN_S);
            default: green_of = CNT_W'(GREEN_M);
        endcase
    endfunction

    always_comb begin
        starved = 4'b0000;
        for (int n = 0; n < 4; n++) starved[n] = (wait_cnt[n] == LIMIT);
    end

    // Starved requests are taken lowest-index first: a fixed pointer of 0.
    rr_arbiter4 u_starve (.req(starved), .ptr(2'd0),  .gnt(st_gnt), .idx(st_idx), .hit(st_hit));
    rr_arbiter4 u_rr     (.req(pending), .ptr(rr_ptr), .gnt(rr_gnt), .idx(rr_idx), .hit(rr_hit));

    // An emergency arriving during a normal offer cancels it; no handshake that cycle.
    assign withdraw  = (state == ISSUE) && emerg_req && !emerg_active;
    assign handshake = (state == ISSUE) && grant_valid && grant_ready && !withdraw;
    assign clr_mask  = handshake ? grant_oh : 4'b0000;
    assign pending_o = pending;

    // Clear beats set; a level request re-latches one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending <= 4'b0000;
        else      pending <= (pending | req_i) & ~clr_mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 4; n++) wait_cnt[n] <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (clr_mask[n] || !pending[n])
                    wait_cnt[n] <= '0;
                else if (!(state == ACTIVE && grant_phase == 2'(n)) && wait_cnt[n] != LIMIT)
                    wait_cnt[n] <= wait_cnt[n] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= CLEAR;
            clr_cnt      <= CLR_LOAD;
            all_red      <= 1'b1;
            grant_valid  <= 1'b0;
            grant_phase  <= 2'd0;
            grant_cycles <= '0;
            grant_oh     <= 4'b0000;
            abort        <= 1'b0;
            emerg_active <= 1'b0;
            rr_ptr       <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (emerg_req) begin
                        state        <= ISSUE;
                        grant_valid  <= 1'b1;
                        grant_phase  <= EPH;
                        grant_oh     <= 4'b0001 << EPH;
                        grant_cycles <= CNT_W'(GREEN_M);
                        emerg_active <= 1'b1;
                    end else if (st_hit) begin
                        state        <= ISSUE;
                        grant_valid  <= 1'b1;
                        grant_phase  <= st_idx;
                        grant_oh     <= st_gnt;
                        grant_cycles <= green_of(st_idx);
                    end else if (rr_hit) begin
                        state        <= ISSUE;
                        grant_valid  <= 1'b1;
                        grant_phase  <= rr_idx;
                        grant_oh     <= rr_gnt;
                        grant_cycles <= green_of(rr_idx);
                    end
                end
                ISSUE: begin
                    if (withdraw) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                    end else if (grant_ready) begin
                        state       <= ACTIVE;
                        grant_valid <= 1'b0;
                        if (!emerg_active) rr_ptr <= grant_phase + 2'd1;
                    end
                end
                ACTIVE: begin
                    // abort is high for one cycle before clearance starts
                    if (abort || phase_done) begin
                        state        <= CLEAR;
                        abort        <= 1'b0;
                        all_red      <= 1'b1;
                        clr_cnt      <= CLR_LOAD;
                        emerg_active <= 1'b0;
                    end else if (emerg_req && !emerg_active) begin
                        abort <= 1'b1;
                    end
                end
                default: begin
                    if (clr_cnt <= CNT_W'(1)) begin
                        state   <= IDLE;
                        all_red <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
